// File: rtl/f32_wrfifo_pkg.sv
// Shared defaults and the write-entry layout for the banked write FIFO.
package f32_wrfifo_pkg;

  localparam int WIDTH   = 256;
  localparam int NUMVBNK = 4;
  localparam int WFFOCNT = 16;
  localparam int BITADDR = 10;

  typedef struct packed {
    logic [BITADDR-1:0] adr;
    logic [WIDTH-1:0]   dat;
  } wr_entry_t;

endpackage

// File: rtl/f32_wrfifo_bank.sv
// One bank of the write FIFO: a compacting shift array whose head is always entry 0,
// so the drain side is driven straight from registers.
module f32_wrfifo_bank
  import f32_wrfifo_pkg::*;
#(
  parameter int DEPTH = WFFOCNT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [BITADDR-1:0]         push_adr,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       push_rdy,
  output logic                       drn_vld,
  output logic [BITADDR-1:0]         drn_adr,
  output logic [WIDTH-1:0]           drn_dat,
  input  logic                       drn_rdy,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       ovf_err
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wr_entry_t       mem     [DEPTH];
  wr_entry_t       shifted [DEPTH];
  wr_entry_t       push_ent;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   wr_idx;
  logic            ovf_q;
  logic            do_push;
  logic            do_pop;

  // A full bank refuses the push even if it pops in the same cycle.
  assign push_rdy = (cnt_q != FULL);
  assign drn_vld  = (cnt_q != '0);
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = drn_vld & drn_rdy;
  assign push_ent = '{adr: push_adr, dat: push_dat};

  assign drn_adr  = mem[0].adr;
  assign drn_dat  = mem[0].dat;
  assign cnt      = cnt_q;
  assign ovf_err  = ovf_q;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    wr_idx = do_pop ? cnt_q - CW'(1) : cnt_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = mem[i+1];
    end
    shifted[DEPTH-1] = mem[DEPTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_vld && cnt_q == FULL) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: the entry array has no reset; entries at or above cnt are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && wr_idx == CW'(i)) begin
        mem[i] <= push_ent;
      end else if (do_pop) begin
        mem[i] <= shifted[i];
      end
    end
  end

endmodule

// File: rtl/f32_wrfifo_drain.sv
// Banked write-drain FIFO: one independent shift-array FIFO per virtual memory bank.
module f32_wrfifo_drain #(
  parameter int WIDTH   = f32_wrfifo_pkg::WIDTH,
  parameter int NUMVBNK = f32_wrfifo_pkg::NUMVBNK,
  parameter int WFFOCNT = f32_wrfifo_pkg::WFFOCNT,
  parameter int BITADDR = f32_wrfifo_pkg::BITADDR
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUMVBNK-1:0]                          push_vld,
  input  logic [NUMVBNK-1:0][BITADDR-1:0]             push_adr,
  input  logic [NUMVBNK-1:0][WIDTH-1:0]               push_dat,
  output logic [NUMVBNK-1:0]                          push_rdy,
  output logic [NUMVBNK-1:0]                          drn_vld,
  output logic [NUMVBNK-1:0][BITADDR-1:0]             drn_adr,
  output logic [NUMVBNK-1:0][WIDTH-1:0]               drn_dat,
  input  logic [NUMVBNK-1:0]                          drn_rdy,
  output logic [NUMVBNK-1:0][$clog2(WFFOCNT+1)-1:0]   fifo_cnt,
  output logic [NUMVBNK-1:0]                          ovf_err
);

  for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
    f32_wrfifo_bank #(
      .DEPTH(WFFOCNT)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (push_vld[b]),
      .push_adr (push_adr[b]),
      .push_dat (push_dat[b]),
      .push_rdy (push_rdy[b]),
      .drn_vld  (drn_vld[b]),
      .drn_adr  (drn_adr[b]),
      .drn_dat  (drn_dat[b]),
      .drn_rdy  (drn_rdy[b]),
      .cnt      (fifo_cnt[b]),
      .ovf_err  (ovf_err[b])
    );
  end

endmodule

// File: tb/tb_f32_wrfifo_drain.sv
// Directed and randomized checks of the banked write-drain FIFO against a per-bank queue model.
module tb_f32_wrfifo_drain;
  import f32_wrfifo_pkg::*;

  localparam int NB = NUMVBNK;
  localparam int CW = $clog2(WFFOCNT + 1);

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NB-1:0]               push_vld;
  logic [NB-1:0][BITADDR-1:0]  push_adr;
  logic [NB-1:0][WIDTH-1:0]    push_dat;
  logic [NB-1:0]               push_rdy;
  logic [NB-1:0]               drn_vld;
  logic [NB-1:0][BITADDR-1:0]  drn_adr;
  logic [NB-1:0][WIDTH-1:0]    drn_dat;
  logic [NB-1:0]               drn_rdy;
  logic [NB-1:0][CW-1:0]       fifo_cnt;
  logic [NB-1:0]               ovf_err;

  int n_checks = 0;
  int n_pass   = 0;

  wr_entry_t q [NB][$];

  f32_wrfifo_drain dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_adr (push_adr),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .drn_vld  (drn_vld),
    .drn_adr  (drn_adr),
    .drn_dat  (drn_dat),
    .drn_rdy  (drn_rdy),
    .fifo_cnt (fifo_cnt),
    .ovf_err  (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 1 ns after the rising edge; outputs are checked in that same window.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int b, input int adr, input int dat);
    push_vld[b] = 1'b1;
    push_adr[b] = BITADDR'(adr);
    push_dat[b] = WIDTH'(dat);
    tick();
    push_vld[b] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    push_vld = '0;
    push_adr = '0;
    push_dat = '0;
    drn_rdy  = '0;
    #12;
    check("rst cnt",      fifo_cnt, '0);
    check("rst drn_vld",  drn_vld,  '0);
    check("rst push_rdy", push_rdy, {NB{1'b1}});
    check("rst ovf",      ovf_err,  '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single push into an idle bank appears on the drain side one cycle later.
    push_one(2, 5, 'hA5);
    check("b2 drn_vld", drn_vld, 4'b0100);
    check("b2 drn_adr", drn_adr[2], 5);
    check("b2 drn_dat", drn_dat[2], 'hA5);
    check("b2 cnt",     fifo_cnt[2], 1);
    check("b0 cnt idle", fifo_cnt[0], 0);
    drn_rdy[2] = 1'b1;
    tick();
    drn_rdy[2] = 1'b0;
    check("b2 cnt drained", fifo_cnt[2], 0);
    check("b2 vld drained", drn_vld, 4'b0000);

    // Fill bank 0 with the drain stalled, then overflow it.
    for (int i = 0; i < WFFOCNT; i++) push_one(0, i, 1000 + i);
    check("b0 full rdy",   push_rdy[0], 0);
    check("b0 full cnt",   fifo_cnt[0], WFFOCNT);
    check("b0 full ovf",   ovf_err, 4'b0000);
    check("b0 stall adr",  drn_adr[0], 0);
    push_vld[0] = 1'b1;
    push_adr[0] = BITADDR'(99);
    push_dat[0] = WIDTH'(99);
    tick();
    check("b0 ovf set",    ovf_err, 4'b0001);
    check("b0 ovf cnt",    fifo_cnt[0], WFFOCNT);
    drn_rdy[0] = 1'b1;
    tick();
    push_vld[0] = 1'b0;
    check("b0 full pushpop cnt", fifo_cnt[0], WFFOCNT - 1);
    for (int i = 1; i < WFFOCNT; i++) begin
      check("b0 drain adr", drn_adr[0], i);
      check("b0 drain dat", drn_dat[0], 1000 + i);
      tick();
    end
    check("b0 empty cnt", fifo_cnt[0], 0);
    check("b0 empty vld", drn_vld[0], 0);
    tick();
    drn_rdy[0] = 1'b0;
    check("b0 no underflow", fifo_cnt[0], 0);
    check("b0 ovf sticky",   ovf_err[0], 1);

    // Simultaneous push and pop with three entries held.
    push_one(1, 10, 2010);
    push_one(1, 11, 2011);
    push_one(1, 12, 2012);
    push_vld[1] = 1'b1;
    push_adr[1] = BITADDR'(13);
    push_dat[1] = WIDTH'(2013);
    drn_rdy[1]  = 1'b1;
    tick();
    push_vld[1] = 1'b0;
    check("b1 pushpop cnt", fifo_cnt[1], 3);
    for (int a = 11; a <= 13; a++) begin
      check("b1 order adr", drn_adr[1], a);
      check("b1 order dat", drn_dat[1], 2000 + a);
      tick();
    end
    drn_rdy[1] = 1'b0;
    check("b1 empty cnt", fifo_cnt[1], 0);

    // Push and pop on a single entry: the new entry is presented with no bubble.
    push_one(3, 20, 3020);
    push_vld[3] = 1'b1;
    push_adr[3] = BITADDR'(21);
    push_dat[3] = WIDTH'(3021);
    drn_rdy[3]  = 1'b1;
    tick();
    push_vld[3] = 1'b0;
    drn_rdy[3]  = 1'b0;
    check("b3 nobubble vld", drn_vld[3], 1);
    check("b3 nobubble adr", drn_adr[3], 21);
    check("b3 nobubble dat", drn_dat[3], 3021);
    check("b3 nobubble cnt", fifo_cnt[3], 1);
    drn_rdy[3] = 1'b1;
    tick();
    drn_rdy[3] = 1'b0;
    check("b3 empty cnt", fifo_cnt[3], 0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 8; i++) push_one(0, 40 + i, 4040 + i);
    drn_rdy[0] = 1'b1;
    tick();
    check("b0 mid cnt", fifo_cnt[0], 7);
    #2 rst_n = 1'b0;
    #1;
    check("async rst cnt",      fifo_cnt, '0);
    check("async rst drn_vld",  drn_vld,  '0);
    check("async rst push_rdy", push_rdy, {NB{1'b1}});
    check("async rst ovf",      ovf_err,  '0);
    drn_rdy = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_one(0, 77, 4077);
    check("post rst vld", drn_vld, 4'b0001);
    check("post rst cnt", fifo_cnt[0], 1);
    check("post rst adr", drn_adr[0], 77);
    drn_rdy[0] = 1'b1;
    tick();
    drn_rdy[0] = 1'b0;
    check("post rst empty", fifo_cnt[0], 0);

    // Random traffic on all banks against the queue model; push-heavy then drain-heavy.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int b = 0; b < NB; b++) begin
        push_vld[b] = ($urandom_range(0, 99) < ((cyc < 5000) ? 70 : 35));
        drn_rdy[b]  = ($urandom_range(0, 99) < ((cyc < 5000) ? 40 : 70));
        push_adr[b] = BITADDR'($urandom);
        push_dat[b] = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
      end
      for (int b = 0; b < NB; b++) begin
        check("rnd drn_vld",  drn_vld[b],  q[b].size() != 0);
        check("rnd push_rdy", push_rdy[b], q[b].size() != WFFOCNT);
        check("rnd cnt",      fifo_cnt[b], q[b].size());
        if (q[b].size() != 0) begin
          check("rnd drn_adr", drn_adr[b], q[b][0].adr);
          check("rnd drn_dat", drn_dat[b], q[b][0].dat);
        end
      end
      for (int b = 0; b < NB; b++) begin
        bit can_push;
        can_push = (q[b].size() != WFFOCNT);
        if (drn_rdy[b] && q[b].size() != 0) void'(q[b].pop_front());
        if (push_vld[b] && can_push) q[b].push_back('{adr: push_adr[b], dat: push_dat[b]});
      end
      tick();
    end
    push_vld = '0;
    drn_rdy  = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/f32_wrfifo_drain.md
F32_WRFIFO_DRAIN -- requirements
Module: f32_wrfifo_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 256, data width of one write entry.
REQ-002 SHALL have parameter NUMVBNK, default 4, number of virtual banks, one FIFO per bank.
REQ-003 SHALL have parameter WFFOCNT, default 16, entries per bank FIFO.
REQ-004 SHALL have parameter BITADDR, default 10, entry address width.
REQ-005 SHALL have port clk, input, 1, sole clock, all state on posedge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port push_vld, input, [NUMVBNK], per-bank write-entry valid.
REQ-008 SHALL have port push_adr, input, [NUMVBNK][BITADDR], per-bank write address.
REQ-009 SHALL have port push_dat, input, [NUMVBNK][WIDTH], per-bank write data.
REQ-010 SHALL have port push_rdy, output, [NUMVBNK], bank FIFO can accept.
REQ-011 SHALL have port drn_vld, output, [NUMVBNK], head entry valid toward the memory bank.
REQ-012 SHALL have port drn_adr, output, [NUMVBNK][BITADDR], head entry address.
REQ-013 SHALL have port drn_dat, output, [NUMVBNK][WIDTH], head entry data.
REQ-014 SHALL have port drn_rdy, input, [NUMVBNK], memory bank accepts the head this cycle.
REQ-015 SHALL have port fifo_cnt, output, [NUMVBNK][$clog2(WFFOCNT+1)], per-bank occupancy.
REQ-016 SHALL have port ovf_err, output, [NUMVBNK], sticky push-while-full flag.

Function
REQ-017 SHALL store each bank as a compacting shift array: head always at entry 0, valid entries 0..cnt-1 contiguous.
REQ-018 SHALL push on push_vld&push_rdy and pop on drn_vld&drn_rdy, per bank, independently across banks.
REQ-019 SHALL on pop only: entry i <= entry i+1 for i<cnt-1, cnt decrements by 1.
REQ-020 SHALL on push only: entry cnt <= push data/address, cnt increments by 1.
REQ-021 SHALL on simultaneous push and pop: entries shift by one, new entry written at cnt-1, cnt unchanged.
REQ-022 SHALL on push and pop with cnt==1: new entry lands at entry 0 with no bubble.
REQ-023 SHALL drive push_rdy = (cnt != WFFOCNT); a full bank does not accept a push even when popping the same cycle.
REQ-024 SHALL set ovf_err[b] when push_vld[b] is high while cnt==WFFOCNT; it is cleared only by reset.
REQ-025 SHALL drive drn_vld = (cnt != 0) and drn_adr/drn_dat = entry 0 directly from registers, with no combinational path from push_* to drn_*.
REQ-026 SHALL give push-to-drain latency of 1 cycle: a push into an empty bank presents drn_vld the next cycle.
REQ-027 SHALL hold drn_vld/drn_adr/drn_dat stable while drn_vld&!drn_rdy (no retraction).
REQ-028 SHALL ignore drn_rdy when drn_vld is low; the count never underflows.
REQ-029 SHALL leave entries at or above cnt don't-care; they are not reset.

Reset
REQ-030 SHALL on rst_n low asynchronously force cnt=0, drn_vld=0, push_rdy=1, ovf_err=0 for all banks.
REQ-031 SHALL discard entries on reset mid-operation; the first push after rst_n rises drains as the sole entry.
REQ-032 SHALL reset no data/address storage; drn_adr/drn_dat are don't-care while drn_vld=0.

Structure
REQ-033 SHALL take WIDTH, NUMVBNK, WFFOCNT and BITADDR defaults, and an entry struct {adr, dat}, from shared package f32_wrfifo_pkg.
REQ-034 SHALL instantiate one sub-module f32_wrfifo_bank per bank, holding the shift array, counter, and overflow flag.
REQ-035 SHALL contain no logic at top level beyond the generate loop over banks.

Verification
REQ-036 SHALL cover: reset, then push adr=5 dat=0xA5 to bank 2 -> next cycle drn_vld[2]=1, drn_adr=5, fifo_cnt[2]=1; other banks idle.
REQ-037 SHALL cover: 16 pushes to bank 0 with drn_rdy=0 -> push_rdy[0]=0 and cnt=16; a 17th push_vld sets ovf_err[0]=1 and the data is dropped.
REQ-038 SHALL cover: bank 1 holding 3 entries, push+pop in the same cycle -> cnt stays 3, order preserved, new entry is the last drained.
REQ-039 SHALL cover: cnt==1 with push+pop -> next cycle drn_vld=1 carrying the new entry, no idle cycle.
REQ-040 SHALL cover: 8 entries, then rst_n low for 1 cycle mid-drain -> all cnt=0, ovf_err=0, drn_vld=0 immediately (asynchronous).
REQ-041 SHALL cover: random push/drn_rdy on all 4 banks for 10k cycles, checked against a per-bank queue model -> exact in-order match, no loss or duplication.
